// File: rtl/onehot_ring_monitor_if.sv
// Ring interface between a rotating one-hot writer and its reader-side monitor.
// The writer drives the ring sample, qualifier and counter clear; the monitor returns status.
interface onehot_ring_monitor_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0]     ring_in;
  logic                 ring_valid;
  logic                 clear;
  logic [IDX_W-1:0]     index;
  logic                 index_valid;
  logic                 locked;
  logic                 error;
  logic [CNT_WIDTH-1:0] wrap_count;
  logic [CNT_WIDTH-1:0] error_count;

  modport master (
    output ring_in, ring_valid, clear,
    input  index, index_valid, locked, error, wrap_count, error_count
  );

  modport slave (
    input  ring_in, ring_valid, clear,
    output index, index_valid, locked, error, wrap_count, error_count
  );
endinterface

// File: rtl/onehot_ring_monitor.sv
// Reader-side monitor for a shift-left-with-wrap one-hot ring: encodes the position,
// checks each qualified step is a hold or a single advance, counts wraps and violations.
module onehot_ring_monitor #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  onehot_ring_monitor_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t               state_q, state_nxt;
  logic [IDX_W-1:0]     index_q, index_nxt;
  logic                 error_q, error_nxt;
  logic [CNT_WIDTH-1:0] wrap_q, errc_q;
  logic                 wrap_inc, err_inc;

  logic                 onehot;
  logic [IDX_W-1:0]     enc;
  logic [IDX_W-1:0]     expected;

  always_comb begin
    int ones;
    ones = 0;
    enc  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.ring_in[i]) begin
        ones = ones + 1;
        enc  = IDX_W'(i);
      end
    end
    onehot = (ones == 1);
  end

  // Wrap at WIDTH-1 explicitly so non-power-of-two rings advance correctly.
  assign expected = (index_q == LAST) ? '0 : index_q + IDX_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= UNLOCKED;
      index_q <= '0;
      error_q <= 1'b0;
      wrap_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_nxt;
      index_q <= index_nxt;
      error_q <= error_nxt;
      if (bus.clear)                   wrap_q <= '0;
      else if (wrap_inc && wrap_q != '1) wrap_q <= wrap_q + CNT_WIDTH'(1);
      if (bus.clear)                   errc_q <= '0;
      else if (err_inc && errc_q != '1)  errc_q <= errc_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state_q;
    index_nxt = index_q;
    error_nxt = 1'b0;
    wrap_inc  = 1'b0;
    err_inc   = 1'b0;
    if (bus.ring_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (onehot) begin
            index_nxt = enc;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (onehot && enc == index_q) begin
            state_nxt = LOCKED;
          end else if (onehot && enc == expected) begin
            index_nxt = enc;
            wrap_inc  = (index_q == LAST);
          end else begin
            // Index keeps its last good value; relock needs a later one-hot sample.
            error_nxt = 1'b1;
            err_inc   = 1'b1;
            state_nxt = UNLOCKED;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    bus.index       = index_q;
    bus.locked      = (state_q == LOCKED);
    bus.index_valid = (state_q == LOCKED);
    bus.error       = error_q;
    bus.wrap_count  = wrap_q;
    bus.error_count = errc_q;
  end
endmodule

// File: tb/tb_onehot_ring_monitor.sv
// Directed bench for onehot_ring_monitor: a WIDTH=4/CNT_WIDTH=4 ring and a WIDTH=3 ring.
module tb_onehot_ring_monitor;
  logic clock = 1'b0;
  logic reset4, reset3;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clock = ~clock;

  onehot_ring_monitor_if #(.WIDTH(4), .CNT_WIDTH(4)) bus4 ();
  onehot_ring_monitor_if #(.WIDTH(3), .CNT_WIDTH(4)) bus3 ();

  onehot_ring_monitor #(.WIDTH(4), .CNT_WIDTH(4)) dut4 (
    .clock (clock),
    .reset (reset4),
    .bus   (bus4)
  );

  onehot_ring_monitor #(.WIDTH(3), .CNT_WIDTH(4)) dut3 (
    .clock (clock),
    .reset (reset3),
    .bus   (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive4(input logic [3:0] ring, input logic vld, input logic clr);
    bus4.ring_in    = ring;
    bus4.ring_valid = vld;
    bus4.clear      = clr;
    tick();
  endtask

  task automatic drive3(input logic [2:0] ring, input logic vld);
    bus3.ring_in    = ring;
    bus3.ring_valid = vld;
    bus3.clear      = 1'b0;
    tick();
  endtask

  task automatic st4(input string tag, input int idx, input int lk, input int er,
                     input int wc, input int ec);
    chk({tag, ".index"},       32'(bus4.index),       32'(idx));
    chk({tag, ".locked"},      32'(bus4.locked),      32'(lk));
    chk({tag, ".index_valid"}, 32'(bus4.index_valid), 32'(lk));
    chk({tag, ".error"},       32'(bus4.error),       32'(er));
    chk({tag, ".wrap_count"},  32'(bus4.wrap_count),  32'(wc));
    chk({tag, ".error_count"}, 32'(bus4.error_count), 32'(ec));
  endtask

  task automatic st3(input string tag, input int idx, input int lk, input int er,
                     input int wc, input int ec);
    chk({tag, ".index"},       32'(bus3.index),       32'(idx));
    chk({tag, ".locked"},      32'(bus3.locked),      32'(lk));
    chk({tag, ".index_valid"}, 32'(bus3.index_valid), 32'(lk));
    chk({tag, ".error"},       32'(bus3.error),       32'(er));
    chk({tag, ".wrap_count"},  32'(bus3.wrap_count),  32'(wc));
    chk({tag, ".error_count"}, 32'(bus3.error_count), 32'(ec));
  endtask

  initial begin
    reset4 = 1'b1;
    reset3 = 1'b1;
    bus4.ring_in = 4'b0010; bus4.ring_valid = 1'b1; bus4.clear = 1'b0;
    bus3.ring_in = 3'b000;  bus3.ring_valid = 1'b0; bus3.clear = 1'b0;

    // Reset held two cycles with a valid one-hot sample present
    tick(); st4("rst_c1", 0, 0, 0, 0, 0);
    tick(); st4("rst_c2", 0, 0, 0, 0, 0);
    reset4 = 1'b0;
    drive4(4'b0010, 1'b0, 1'b0); st4("rst_rel", 0, 0, 0, 0, 0);
    drive4(4'b0010, 1'b1, 1'b0); st4("rst_lock", 1, 1, 0, 0, 0);

    // Legal rotation from a fresh reset
    reset4 = 1'b1; tick(); reset4 = 1'b0;
    drive4(4'b0001, 1'b1, 1'b0); st4("rot0", 0, 1, 0, 0, 0);
    drive4(4'b0010, 1'b1, 1'b0); st4("rot1", 1, 1, 0, 0, 0);
    drive4(4'b0010, 1'b1, 1'b0); st4("rot_hold", 1, 1, 0, 0, 0);
    drive4(4'b0100, 1'b1, 1'b0); st4("rot2", 2, 1, 0, 0, 0);
    drive4(4'b1000, 1'b1, 1'b0); st4("rot3", 3, 1, 0, 0, 0);
    drive4(4'b0001, 1'b1, 1'b0); st4("rot_wrap", 0, 1, 0, 1, 0);

    // Violations: skip from 1 to 3, zero vector, garbage while unlocked
    drive4(4'b0010, 1'b1, 1'b0); st4("v_lock1", 1, 1, 0, 1, 0);
    drive4(4'b1000, 1'b1, 1'b0); st4("v_skip", 1, 0, 1, 1, 1);
    drive4(4'b0001, 1'b1, 1'b0); st4("v_relock", 0, 1, 0, 1, 1);
    drive4(4'b0000, 1'b1, 1'b0); st4("v_zero", 0, 0, 1, 1, 2);
    drive4(4'b0110, 1'b1, 1'b0); st4("v_garbage", 0, 0, 0, 1, 2);

    // Qualification: unqualified garbage is ignored
    drive4(4'b0100, 1'b1, 1'b0); st4("q_lock2", 2, 1, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      drive4(4'b1111, 1'b0, 1'b0); st4("q_idle", 2, 1, 0, 1, 2);
    end
    drive4(4'b1000, 1'b1, 1'b0); st4("q_adv", 3, 1, 0, 1, 2);

    // Saturation: 17 more wraps on top of 1 must stick at 15
    for (int r = 0; r < 17; r++) begin
      drive4(4'b0001, 1'b1, 1'b0);
      drive4(4'b0010, 1'b1, 1'b0);
      drive4(4'b0100, 1'b1, 1'b0);
      drive4(4'b1000, 1'b1, 1'b0);
    end
    st4("sat", 3, 1, 0, 15, 2);
    // Clear wins over a wrapping advance; both counters zero
    drive4(4'b0001, 1'b1, 1'b1); st4("clr_wrap", 0, 1, 0, 0, 0);
    drive4(4'b0001, 1'b0, 1'b0); st4("clr_after", 0, 1, 0, 0, 0);

    // WIDTH=3: wrap happens at index 2, not 3
    bus4.ring_valid = 1'b0;
    reset3 = 1'b0;
    drive3(3'b001, 1'b1); st3("w3_0", 0, 1, 0, 0, 0);
    drive3(3'b010, 1'b1); st3("w3_1", 1, 1, 0, 0, 0);
    drive3(3'b100, 1'b1); st3("w3_2", 2, 1, 0, 0, 0);
    drive3(3'b001, 1'b1); st3("w3_wrap", 0, 1, 0, 1, 0);
    reset3 = 1'b1;
    drive3(3'b010, 1'b1); st3("w3_rst", 0, 0, 0, 0, 0);
    reset3 = 1'b0;
    drive3(3'b100, 1'b1); st3("w3_lock2", 2, 1, 0, 0, 0);
    drive3(3'b001, 1'b1); st3("w3_wrap2", 0, 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
